// File: rtl/key_step_conditioner.sv
// Debounced push-button conditioner: per-channel two-flop synchronizer, 4-state
// debounce FSM, registered level and one-cycle step pulse. Optional auto-repeat: KEY_AUTOREPEAT_EN.
module key_step_conditioner #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] level,
  output logic [NKEYS-1:0] step
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  // The entering sample counts as the first, so acceptance is at count DEBOUNCE_CYCLES-2.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CNT = 2'd1,
    HELD      = 2'd2,
    REL_CNT   = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  logic [NKEYS-1:0] sync1_r, sync2_r;
  logic [NKEYS-1:0] pressed_s;

  // Two-flop synchronizer, resets to the released level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {NKEYS{1'b1}};
      sync2_r <= {NKEYS{1'b1}};
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = ~sync2_r;

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          accept_s, step_s, level_s;
    logic          level_r, step_r;

    // Debounce next-state logic
    always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      accept_s = 1'b0;
      case (state_r)
        IDLE: begin
          cnt_s = {CW{1'b0}};
          if (pressed_s[i]) state_s = PRESS_CNT;
          else              state_s = IDLE;
        end
        PRESS_CNT: begin
          if (!pressed_s[i]) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
          end else if (cnt_r >= CNT_LAST) begin
            state_s  = HELD;
            cnt_s    = {CW{1'b0}};
            accept_s = 1'b1;
          end else begin
            cnt_s = sat_inc(cnt_r);
          end
        end
        HELD: begin
          cnt_s = {CW{1'b0}};
          if (!pressed_s[i]) state_s = REL_CNT;
          else               state_s = HELD;
        end
        REL_CNT: begin
          if (pressed_s[i]) begin
            state_s = HELD;
            cnt_s   = {CW{1'b0}};
          end else if (cnt_r >= CNT_LAST) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
          end else begin
            cnt_s = sat_inc(cnt_r);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end
      endcase
      level_s = (state_s == HELD) || (state_s == REL_CNT);
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_r, rpt_s;
    logic          rep_r, rep_s, fire_s;

    // Repeat timer runs only while staying in HELD; first interval is the longer delay
    always_comb begin
      rpt_s  = {RW{1'b0}};
      rep_s  = 1'b0;
      fire_s = 1'b0;
      if (state_r == HELD && pressed_s[i]) begin
        if (rpt_r >= (rep_r ? RPT_PER_LAST : RPT_DLY_LAST)) begin
          fire_s = 1'b1;
          rep_s  = 1'b1;
        end else begin
          rpt_s = rpt_r + {{(RW-1){1'b0}}, 1'b1};
          rep_s = rep_r;
        end
      end else begin
        rpt_s = {RW{1'b0}};
      end
      step_s = accept_s | fire_s;
    end

    // Repeat timer registers
    always_ff @(posedge clk) begin
      if (reset) begin
        rpt_r <= {RW{1'b0}};
        rep_r <= 1'b0;
      end else begin
        rpt_r <= rpt_s;
        rep_r <= rep_s;
      end
    end
`else
    assign step_s = accept_s;
`endif

    // Channel state and registered outputs; reset also suppresses a due step
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= IDLE;
        cnt_r   <= {CW{1'b0}};
        level_r <= 1'b0;
        step_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        level_r <= level_s;
        step_r  <= step_s;
      end
    end

    assign level[i] = level_r;
    assign step[i]  = step_r;
  end

endmodule

// File: tb/tb_key_step_conditioner.sv
// Directed, table-driven bench for key_step_conditioner (NKEYS=4, DEBOUNCE_CYCLES=4).
module tb_key_step_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] level;
  logic [NK-1:0] step;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] key_n;
    logic [3:0] lvl;
    logic [3:0] stp;
  } vec_t;

  vec_t vecs[$];

  key_step_conditioner #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .level(level), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [3:0] k, input logic [3:0] l, input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{k, l, s});
  endtask

  // Drive inputs at the falling edge, sample just after the following rising edge.
  task automatic tick(input logic [3:0] k, input logic r);
    @(negedge clk);
    key_n = k;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Key 0 held through a one-cycle reset at relative edge off; acceptance restarts after it.
  task automatic rst_seq(input int off);
    logic [3:0] el, es;
    for (int t = 0; t <= off + 9; t++) begin
      tick(4'b1110, (t == off) ? 1'b1 : 1'b0);
      el = (t >= off + 6) ? 4'b0001 : 4'b0000;
      es = (t == off + 6) ? 4'b0001 : 4'b0000;
      chk("rst_level", t, level, el);
      chk("rst_step", t, step, es);
    end
    for (int t = 0; t < 8; t++) tick(4'b1111, 1'b0);
    chk("rst_release_level", off, level, 4'b0000);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    key_n    = 4'b1111;
    reset    = 1'b1;

    // Single key press, hold and release on key 0
    add(4'b1111, 4'b0000, 4'b0000, 2);
    add(4'b1110, 4'b0000, 4'b0000, 5);
    add(4'b1110, 4'b0001, 4'b0001, 1);
    add(4'b1110, 4'b0001, 4'b0000, 8);
    add(4'b1111, 4'b0001, 4'b0000, 5);
    add(4'b1111, 4'b0000, 4'b0000, 3);
    // Bouncing key 1: low/high every two cycles for 20 cycles
    for (int i = 0; i < 5; i++) begin
      add(4'b1101, 4'b0000, 4'b0000, 2);
      add(4'b1111, 4'b0000, 4'b0000, 2);
    end
    add(4'b1111, 4'b0000, 4'b0000, 4);
    // Key 2: short release glitch is absorbed, long release drops level
    add(4'b1011, 4'b0000, 4'b0000, 5);
    add(4'b1011, 4'b0100, 4'b0100, 1);
    add(4'b1011, 4'b0100, 4'b0000, 2);
    add(4'b1111, 4'b0100, 4'b0000, 3);
    add(4'b1011, 4'b0100, 4'b0000, 6);
    add(4'b1111, 4'b0100, 4'b0000, 5);
    add(4'b1111, 4'b0000, 4'b0000, 3);
    // All four keys pressed on the same edge
    add(4'b0000, 4'b0000, 4'b0000, 5);
    add(4'b0000, 4'b1111, 4'b1111, 1);
    add(4'b0000, 4'b1111, 4'b0000, 3);
    add(4'b1111, 4'b1111, 4'b0000, 5);
    add(4'b1111, 4'b0000, 4'b0000, 3);

    for (int i = 0; i < 3; i++) tick(4'b1111, 1'b1);
    chk("reset_level", 0, level, 4'b0000);
    chk("reset_step", 0, step, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].key_n, 1'b0);
      chk("vec_level", i, level, vecs[i].lvl);
      chk("vec_step", i, step, vecs[i].stp);
    end

    rst_seq(4);
    rst_seq(5);

    // Long hold on key 0: one step only, or the auto-repeat train when enabled
    begin
      int ta;
      logic ar;
      logic [3:0] el, es;
      logic sb;
      ta = 5;
`ifdef KEY_AUTOREPEAT_EN
      ar = 1'b1;
`else
      ar = 1'b0;
`endif
      for (int t = 0; t <= ta + 38; t++) begin
        tick((t <= ta + 28) ? 4'b1110 : 4'b1111, 1'b0);
        sb = (t == ta) ||
             (ar && t >= ta + RD && t <= ta + 28 && ((t - ta - RD) % RP) == 0);
        es = {3'b000, sb};
        el = (t >= ta && t < ta + 34) ? 4'b0001 : 4'b0000;
        chk("hold_level", t, level, el);
        chk("hold_step", t, step, es);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
